hazard_ctrl: RTL and testbench

//  Central pipeline stall/flush sequencer, directly downstream of the load-use detector.

---
 rtl/hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush sequencer: merges load-use, EX redirect and bus-busy hazards
// into per-stage F/D/E/M/W controls. Optional perf counters under HAZARD_CTRL_PERF_EN.
module hazard_ctrl #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_stall,
  input  logic             ex_redirect,
  input  logic             i_busy,
  input  logic             d_busy,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic             redirect_ok,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] DISCARD = 1'b1;

  logic [0:0] state_q, state_d;

  logic stall_f_c, stall_d_c, stall_e_c, stall_m_c;
  logic flush_d_c, flush_e_c, flush_w_c, redirect_ok_c;
  logic bubble_c;

  always_comb begin
    state_d       = state_q;
    stall_f_c     = 1'b0;
    stall_d_c     = 1'b0;
    stall_e_c     = 1'b0;
    stall_m_c     = 1'b0;
    flush_d_c     = 1'b0;
    flush_e_c     = 1'b0;
    flush_w_c     = 1'b0;
    redirect_ok_c = 1'b0;
    bubble_c      = 1'b0;
    if (d_busy) begin
      // E is frozen, so a pending redirect is simply seen again once M drains
      stall_f_c = 1'b1;
      stall_d_c = 1'b1;
      stall_e_c = 1'b1;
      stall_m_c = 1'b1;
      flush_w_c = 1'b1;
    end else if (ex_redirect) begin
      redirect_ok_c = 1'b1;
      flush_d_c     = 1'b1;
      flush_e_c     = 1'b1;
      if (i_busy) begin
        state_d   = DISCARD;
        stall_f_c = 1'b1;
      end else begin
        state_d   = RUN;
      end
    end else if (state_q == DISCARD) begin
      flush_d_c = 1'b1;
      if (i_busy) begin
        stall_f_c = 1'b1;
      end else begin
        state_d   = RUN;
      end
    end else if (load_stall) begin
      stall_f_c = 1'b1;
      stall_d_c = 1'b1;
      flush_e_c = 1'b1;
      bubble_c  = 1'b1;
    end else if (i_busy) begin
      stall_f_c = 1'b1;
      flush_d_c = 1'b1;
    end
  end

  // While in reset the pipeline sees bubbles in D and E and nothing else
  assign stall_f     = reset_n & stall_f_c;
  assign stall_d     = reset_n & stall_d_c;
  assign stall_e     = reset_n & stall_e_c;
  assign stall_m     = reset_n & stall_m_c;
  assign flush_d     = ~reset_n | flush_d_c;
  assign flush_e     = ~reset_n | flush_e_c;
  assign flush_w     = reset_n & flush_w_c;
  assign redirect_ok = reset_n & redirect_ok_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, stall_f_c};
    bubble_cnt_d   = bubble_cnt_q   + {{(CNT_W-1){1'b0}}, bubble_c};
    redirect_cnt_d = redirect_cnt_q + {{(CNT_W-1){1'b0}}, redirect_ok_c};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles_q <= '0;
      bubble_cnt_q   <= '0;
      redirect_cnt_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      bubble_cnt_q   <= bubble_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign bubble_cnt   = bubble_cnt_q;
  assign redirect_cnt = redirect_cnt_q;
`else
  logic unused_perf;
  assign unused_perf  = bubble_c;
  assign stall_cycles = '0;
  assign bubble_cnt   = '0;
  assign redirect_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; counter expectations follow HAZARD_CTRL_PERF_EN.
module tb_hazard_ctrl;

`ifdef HAZARD_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic load_stall, ex_redirect, i_busy, d_busy;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w, redirect_ok;
  logic [3:0] stall_cycles, bubble_cnt, redirect_cnt;
  logic [7:0] outs;

  int n_chk  = 0;
  int n_fail = 0;
  logic [3:0] exp_stall = 4'd0, exp_bubble = 4'd0, exp_redir = 4'd0;

  hazard_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .load_stall(load_stall), .ex_redirect(ex_redirect), .i_busy(i_busy), .d_busy(d_busy),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w), .redirect_ok(redirect_ok),
    .stall_cycles(stall_cycles), .bubble_cnt(bubble_cnt), .redirect_cnt(redirect_cnt)
  );

  // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, redirect_ok}
  assign outs = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, redirect_ok};

  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] v);
    {load_stall, ex_redirect, i_busy, d_busy} = v;
  endtask

  // Advance the counter model by what one clock of the given outputs should add.
  task automatic tick(input logic [7:0] e);
    if (e[7]) exp_stall = exp_stall + 4'd1;
    if (e[0]) exp_redir = exp_redir + 4'd1;
    if (e == 8'b1100_0100) exp_bubble = exp_bubble + 4'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    drive(4'b0110);
    #2;
    n_chk++;
    if (outs !== 8'b0000_1100) begin
      n_fail++; $display("FAIL reset_outs got=%b want=%b", outs, 8'b0000_1100);
    end
    n_chk++;
    if ({stall_cycles, bubble_cnt, redirect_cnt} !== 12'h000) begin
      n_fail++; $display("FAIL reset_cnt got=%h want=000", {stall_cycles, bubble_cnt, redirect_cnt});
    end
    @(posedge clk); #1;
    n_chk++;
    if (outs !== 8'b0000_1100) begin
      n_fail++; $display("FAIL reset_hold got=%b want=%b", outs, 8'b0000_1100);
    end
    drive(4'b0000);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_chk++;
    if (outs !== 8'b0) begin
      n_fail++; $display("FAIL reset_release got=%b want=00000000", outs);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bubble;
    logic [3:0] vin [2] = '{4'b1000, 4'b0000};
    logic [7:0] vex [2] = '{8'b1100_0100, 8'b0000_0000};
    for (int i = 0; i < 2; i++) begin
      drive(vin[i]);
      @(negedge clk);
      n_chk++;
      if (outs !== vex[i]) begin
        n_fail++; $display("FAIL bubble[%0d] got=%b want=%b", i, outs, vex[i]);
      end
      tick(vex[i]);
    end
    n_chk++;
    if (bubble_cnt !== (PERF ? exp_bubble : 4'd0)) begin
      n_fail++; $display("FAIL bubble_cnt got=%0d want=%0d", bubble_cnt, PERF ? exp_bubble : 4'd0);
    end
  endtask

  task automatic test_dbusy;
    logic [3:0] vin [5] = '{4'b1101, 4'b1101, 4'b1101, 4'b1100, 4'b0000};
    logic [7:0] vex [5] = '{8'b1111_0010, 8'b1111_0010, 8'b1111_0010, 8'b0000_1101, 8'b0};
    for (int i = 0; i < 5; i++) begin
      drive(vin[i]);
      @(negedge clk);
      n_chk++;
      if (outs !== vex[i]) begin
        n_fail++; $display("FAIL dbusy[%0d] got=%b want=%b", i, outs, vex[i]);
      end
      tick(vex[i]);
    end
    n_chk++;
    if ({stall_cycles, redirect_cnt} !== (PERF ? {exp_stall, exp_redir} : 8'h00)) begin
      n_fail++; $display("FAIL dbusy_cnt got=%h want=%h", {stall_cycles, redirect_cnt},
                         PERF ? {exp_stall, exp_redir} : 8'h00);
    end
  endtask

  task automatic test_discard;
    logic [3:0] vin [5] = '{4'b0110, 4'b0010, 4'b1010, 4'b0000, 4'b0000};
    logic [7:0] vex [5] = '{8'b1000_1101, 8'b1000_1000, 8'b1000_1000, 8'b0000_1000, 8'b0};
    for (int i = 0; i < 5; i++) begin
      drive(vin[i]);
      @(negedge clk);
      n_chk++;
      if (outs !== vex[i]) begin
        n_fail++; $display("FAIL discard[%0d] got=%b want=%b", i, outs, vex[i]);
      end
      tick(vex[i]);
    end
    n_chk++;
    if ({stall_cycles, bubble_cnt, redirect_cnt} !==
        (PERF ? {exp_stall, exp_bubble, exp_redir} : 12'h000)) begin
      n_fail++; $display("FAIL discard_cnt got=%h want=%h", {stall_cycles, bubble_cnt, redirect_cnt},
                         PERF ? {exp_stall, exp_bubble, exp_redir} : 12'h000);
    end
  endtask

  task automatic test_redirect_in_discard;
    logic [3:0] vin [8] = '{4'b0110, 4'b0110, 4'b0011, 4'b0000, 4'b0000,
                            4'b0110, 4'b0100, 4'b0000};
    logic [7:0] vex [8] = '{8'b1000_1101, 8'b1000_1101, 8'b1111_0010, 8'b0000_1000, 8'b0,
                            8'b1000_1101, 8'b0000_1101, 8'b0};
    for (int i = 0; i < 8; i++) begin
      drive(vin[i]);
      @(negedge clk);
      n_chk++;
      if (outs !== vex[i]) begin
        n_fail++; $display("FAIL redir_disc[%0d] got=%b want=%b", i, outs, vex[i]);
      end
      tick(vex[i]);
    end
  endtask

  task automatic test_ls_vs_redirect;
    logic [3:0] vin [5] = '{4'b1100, 4'b0000, 4'b1010, 4'b0010, 4'b0000};
    logic [7:0] vex [5] = '{8'b0000_1101, 8'b0, 8'b1100_0100, 8'b1000_1000, 8'b0};
    for (int i = 0; i < 5; i++) begin
      drive(vin[i]);
      @(negedge clk);
      n_chk++;
      if (outs !== vex[i]) begin
        n_fail++; $display("FAIL ls_redir[%0d] got=%b want=%b", i, outs, vex[i]);
      end
      tick(vex[i]);
    end
    n_chk++;
    if ({bubble_cnt, redirect_cnt} !== (PERF ? {exp_bubble, exp_redir} : 8'h00)) begin
      n_fail++; $display("FAIL ls_redir_cnt got=%h want=%h", {bubble_cnt, redirect_cnt},
                         PERF ? {exp_bubble, exp_redir} : 8'h00);
    end
  endtask

  task automatic test_reset_discard;
    drive(4'b0110);
    @(negedge clk);
    n_chk++;
    if (outs !== 8'b1000_1101) begin
      n_fail++; $display("FAIL rst_disc_enter got=%b want=%b", outs, 8'b1000_1101);
    end
    tick(8'b1000_1101);
    drive(4'b0010);
    #2;
    n_chk++;
    if (outs !== 8'b1000_1000) begin
      n_fail++; $display("FAIL rst_disc_state got=%b want=%b", outs, 8'b1000_1000);
    end
    reset_n = 1'b0;
    exp_stall = 4'd0; exp_bubble = 4'd0; exp_redir = 4'd0;
    #1;
    n_chk++;
    if (outs !== 8'b0000_1100) begin
      n_fail++; $display("FAIL rst_disc_async got=%b want=%b", outs, 8'b0000_1100);
    end
    n_chk++;
    if ({stall_cycles, bubble_cnt, redirect_cnt} !== 12'h000) begin
      n_fail++; $display("FAIL rst_disc_cnt got=%h want=000", {stall_cycles, bubble_cnt, redirect_cnt});
    end
    drive(4'b0000);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_chk++;
    if (outs !== 8'b0) begin
      n_fail++; $display("FAIL rst_disc_release got=%b want=00000000", outs);
    end
    @(posedge clk); #1;
    n_chk++;
    if (outs !== 8'b0) begin
      n_fail++; $display("FAIL rst_disc_run got=%b want=00000000", outs);
    end
  endtask

  task automatic test_wrap;
    drive(4'b0010);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_chk++;
      if (outs !== 8'b1000_1000 || stall_cycles !== (PERF ? exp_stall : 4'd0)) begin
        n_fail++; $display("FAIL wrap[%0d] outs=%b cnt=%0d want outs=%b cnt=%0d", i, outs,
                           stall_cycles, 8'b1000_1000, PERF ? exp_stall : 4'd0);
      end
      tick(8'b1000_1000);
    end
    drive(4'b0000);
    @(negedge clk);
    n_chk++;
    if (stall_cycles !== 4'd0 || bubble_cnt !== 4'd0 || redirect_cnt !== 4'd0) begin
      n_fail++; $display("FAIL wrap_end got=%0d/%0d/%0d want=0/0/0", stall_cycles, bubble_cnt, redirect_cnt);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(4'b0000);
    test_reset;
    test_bubble;
    test_dbusy;
    test_discard;
    test_redirect_in_discard;
    test_ls_vs_redirect;
    test_reset_discard;
    test_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
